// File: rtl/subleq_sequencer.sv
// subleq_sequencer
//   Control FSM that executes the one-instruction URISC SUBLEQ
//     mem[B] <= mem[B] - mem[A]; if (result <= 0) PC <= C else PC <= PC + 3
//   on a dual-port word memory with registered reads (data valid the cycle
//   after the address). This block is the only master of that memory.
//   Every instruction takes four cycles: FETCH_AB, FETCH_C, OPER, EXEC.
//
// Parameters
//   WORD_SIZE : data, address and PC width
//   START_PC  : PC loaded when start is accepted
//
// Ports
//   clk               clock, all logic on posedge
//   rst_n             synchronous active-low reset
//   start             begin execution at START_PC (accepted in IDLE/HALT only)
//   busy              high while an instruction is in flight
//   halted            high in HALT
//   pc                current program counter
//   retired           executed-instruction count (wraps)
//   add1/dataIn1/write1/dataOut1 : memory port 1 (read-only use)
//   add2/dataIn2/write2/dataOut2 : memory port 2 (reads, and the EXEC write)
//
// Optional build macro
//   SUBLEQ_SELF_LOOP_HALT_EN : a taken branch back onto the same instruction
//   (C == pc) halts instead of spinning forever.
module subleq_sequencer #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] START_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] retired,
  output logic [WORD_SIZE-1:0] add1,
  output logic [WORD_SIZE-1:0] dataIn1,
  output logic                 write1,
  input  logic [WORD_SIZE-1:0] dataOut1,
  output logic [WORD_SIZE-1:0] add2,
  output logic [WORD_SIZE-1:0] dataIn2,
  output logic                 write2,
  input  logic [WORD_SIZE-1:0] dataOut2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_AB,
    S_FETCH_C,
    S_OPER,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [WORD_SIZE-1:0]   r_pc;
  logic [WORD_SIZE-1:0]   r_retired;
  logic [WORD_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_b;
  logic [WORD_SIZE-1:0]   r_c;

  logic [WORD_SIZE-1:0]   w_pc_p1;
  logic [WORD_SIZE-1:0]   w_pc_p2;
  logic [WORD_SIZE-1:0]   w_pc_p3;
  logic signed [WORD_SIZE-1:0] w_diff;
  logic                   w_taken;
  logic                   w_self_loop;

  assign w_pc_p1 = r_pc + WORD_SIZE'(1);
  assign w_pc_p2 = r_pc + WORD_SIZE'(2);
  assign w_pc_p3 = r_pc + WORD_SIZE'(3);

  // In EXEC the registered reads issued in OPER are on the data buses:
  // dataOut1 = mem[A], dataOut2 = mem[B].
  assign w_diff  = dataOut2 - dataOut1;
  assign w_taken = (w_diff == '0) || w_diff[WORD_SIZE-1];

`ifdef SUBLEQ_SELF_LOOP_HALT_EN
  assign w_self_loop = (r_c == r_pc);
`else
  assign w_self_loop = 1'b0;
`endif

  // Port 1 never writes.
  assign dataIn1 = '0;
  assign write1  = 1'b0;

  assign pc      = r_pc;
  assign retired = r_retired;

  always_comb begin
    w_next  = r_state;
    add1    = '0;
    add2    = '0;
    dataIn2 = '0;
    write2  = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH_AB;
      end
      S_FETCH_AB: begin
        busy   = 1'b1;
        add1   = r_pc;
        add2   = w_pc_p1;
        w_next = S_FETCH_C;
      end
      S_FETCH_C: begin
        busy   = 1'b1;
        add1   = w_pc_p2;
        w_next = S_OPER;
      end
      S_OPER: begin
        busy   = 1'b1;
        add1   = r_a;
        add2   = r_b;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        add2    = r_b;
        dataIn2 = w_diff;
        // Gated by reset so an abort during EXEC never corrupts memory.
        write2  = rst_n;
        if (w_taken && (r_c[WORD_SIZE-1] || w_self_loop)) w_next = S_HALT;
        else                                               w_next = S_FETCH_AB;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) w_next = S_FETCH_AB;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_retired <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) r_pc <= START_PC;
        end
        S_FETCH_C: begin
          r_a <= dataOut1;
          r_b <= dataOut2;
        end
        S_OPER: begin
          r_c <= dataOut1;
        end
        S_EXEC: begin
          r_retired <= r_retired + WORD_SIZE'(1);
          r_pc      <= w_taken ? r_c : w_pc_p3;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_sequencer.sv
module tb_subleq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, halted;
  logic [15:0] pc, retired;
  logic [15:0] add1, dataIn1, add2, dataIn2;
  logic        write1, write2;
  logic [15:0] dataOut1 = '0;
  logic [15:0] dataOut2 = '0;

  logic [15:0] mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  subleq_sequencer #(.WORD_SIZE(16), .START_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
    .pc(pc), .retired(retired),
    .add1(add1), .dataIn1(dataIn1), .write1(write1), .dataOut1(dataOut1),
    .add2(add2), .dataIn2(dataIn2), .write2(write2), .dataOut2(dataOut2)
  );

  always #5 clk = ~clk;

  // Dual-port memory with registered reads; writes commit at the edge.
  always @(posedge clk) begin
    if (write2) mem[add2] <= dataIn2;
    dataOut1 <= mem[add1];
    dataOut2 <= mem[add2];
  end

  typedef struct {
    logic [15:0] a, b, c, va, vb;
    logic [15:0] exp_m, exp_pc;
    logic        exp_h;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_retired", retired, 16'h0000);
    chk("rst_busy", {15'b0, busy}, 16'h0000);
    chk("rst_halted", {15'b0, halted}, 16'h0000);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    clear_mem();
    mem[0] = v.a; mem[1] = v.b; mem[2] = v.c;
    mem[v.a] = v.va;
    mem[v.b] = v.vb;
    do_reset();
    do_start();
    chk($sformatf("v%0d_fetch_busy", idx), {15'b0, busy}, 16'h0001);
    chk($sformatf("v%0d_fetch_add2", idx), add2, 16'h0001);
    tick();
    tick();
    tick();
    chk($sformatf("v%0d_exec_write2", idx), {15'b0, write2}, 16'h0001);
    chk($sformatf("v%0d_exec_add2", idx), add2, v.b);
    chk($sformatf("v%0d_exec_data", idx), dataIn2, v.exp_m);
    tick();
    chk($sformatf("v%0d_mem", idx), mem[v.b], v.exp_m);
    chk($sformatf("v%0d_pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d_retired", idx), retired, 16'h0001);
    chk($sformatf("v%0d_halted", idx), {15'b0, halted}, {15'b0, v.exp_h});
    chk($sformatf("v%0d_busy", idx), {15'b0, busy}, {15'b0, !v.exp_h});
  endtask

  initial begin
    //         a      b      c        va       vb       exp_m    exp_pc   halt
    vecs[0] = '{16'd10, 16'd11, 16'd3,    16'd5,    16'd7,    16'd2,    16'd3,    1'b0};
    vecs[1] = '{16'd10, 16'd11, 16'd6,    16'd9,    16'd9,    16'd0,    16'd6,    1'b0};
    vecs[2] = '{16'd10, 16'd11, 16'd6,    16'd1,    16'd0,    16'hFFFF, 16'd6,    1'b0};
    vecs[3] = '{16'd10, 16'd10, 16'hFFFF, 16'd5,    16'd5,    16'd0,    16'hFFFF, 1'b1};
    vecs[4] = '{16'd10, 16'd11, 16'h8000, 16'd10,   16'd7,    16'hFFFD, 16'h8000, 1'b1};
    vecs[5] = '{16'd20, 16'd21, 16'd9,    16'hFFFF, 16'h7FFF, 16'h8000, 16'd9,    1'b0};
    vecs[6] = '{16'd20, 16'd21, 16'd9,    16'd1,    16'h8000, 16'h7FFF, 16'd3,    1'b0};

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Port 1 must stay read-only in every state.
    chk("port1_write", {15'b0, write1}, 16'h0000);
    chk("port1_data", dataIn1, 16'h0000);

    // Halt, then restart: pc reloads, retired is preserved.
    clear_mem();
    mem[0] = 16'd10; mem[1] = 16'd10; mem[2] = 16'hFFFF; mem[10] = 16'd5;
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) tick();
    chk("halt_halted", {15'b0, halted}, 16'h0001);
    chk("halt_busy", {15'b0, busy}, 16'h0000);
    chk("halt_pc", pc, 16'hFFFF);
    chk("halt_mem", mem[10], 16'h0000);
    do_start();
    chk("restart_pc", pc, 16'h0000);
    chk("restart_halted", {15'b0, halted}, 16'h0000);
    chk("restart_busy", {15'b0, busy}, 16'h0001);
    chk("restart_retired", retired, 16'h0001);

    // Reset asserted during EXEC: no write, everything back to IDLE.
    clear_mem();
    mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd3;
    mem[10] = 16'd5; mem[11] = 16'd7;
    do_reset();
    do_start();
    tick();
    tick();
    tick();
    chk("rexec_pre_write2", {15'b0, write2}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("rexec_write2", {15'b0, write2}, 16'h0000);
    tick();
    rst_n = 1'b1;
    chk("rexec_mem", mem[11], 16'd7);
    chk("rexec_pc", pc, 16'h0000);
    chk("rexec_retired", retired, 16'h0000);
    chk("rexec_busy", {15'b0, busy}, 16'h0000);
    chk("rexec_halted", {15'b0, halted}, 16'h0000);

    // Self-modifying code: instruction 1 rewrites instruction 2's B field,
    // and the following fetch must see the new value.
    clear_mem();
    mem[0] = 16'd12; mem[1] = 16'd4;  mem[2] = 16'd3;
    mem[3] = 16'd20; mem[4] = 16'd21; mem[5] = 16'd9;
    mem[12] = 16'hFFFF; mem[20] = 16'd1; mem[21] = 16'd50; mem[22] = 16'd5;
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) tick();
    chk("smc_field", mem[4], 16'd22);
    chk("smc_target", mem[22], 16'd4);
    chk("smc_stale", mem[21], 16'd50);
    chk("smc_pc", pc, 16'd6);
    chk("smc_retired", retired, 16'd2);

    // Self-loop: branch target equals the current instruction.
    clear_mem();
    mem[0] = 16'd10; mem[1] = 16'd10; mem[2] = 16'd0; mem[10] = 16'd3;
    do_reset();
    do_start();
`ifdef SUBLEQ_SELF_LOOP_HALT_EN
    for (int i = 0; i < 4; i++) tick();
    chk("loop_halted", {15'b0, halted}, 16'h0001);
    chk("loop_pc", pc, 16'h0000);
    chk("loop_retired", retired, 16'h0001);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("loop_busy", {15'b0, busy}, 16'h0001);
    chk("loop_halted", {15'b0, halted}, 16'h0000);
    chk("loop_retired", retired, 16'd5);
    chk("loop_pc", pc, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/subleq_sequencer.md
Name: subleq_sequencer

Overview:
- Control FSM that runs the URISC SUBLEQ instruction (mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C, else PC <= PC+3) on the dual-port, registered-read word memory.
- Drives both memory ports. Each port either reads or writes per cycle, and read data is valid the cycle after the address is driven.
- Sits between the top level (start/halt control) and the memory; it is the only master of that memory.

Parameters:
- WORD_SIZE, 16: data, address and PC width.
- START_PC, 0: PC loaded on start.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin execution from START_PC; honoured in IDLE or HALT only.
- busy  out  1  high in FETCH_AB, FETCH_C, OPER, EXEC.
- halted  out  1  high in HALT.
- pc  out  WORD_SIZE  current PC.
- retired  out  WORD_SIZE  count of executed instructions; wraps.
- add1  out  WORD_SIZE  memory port 1 address.
- dataIn1  out  WORD_SIZE  memory port 1 write data (always 0; port 1 is read-only here).
- write1  out  1  memory port 1 write strobe (always 0).
- dataOut1  in  WORD_SIZE  memory port 1 read data.
- add2  out  WORD_SIZE  memory port 2 address.
- dataIn2  out  WORD_SIZE  memory port 2 write data.
- write2  out  1  memory port 2 write strobe.
- dataOut2  in  WORD_SIZE  memory port 2 read data.

Behaviour:
- Clock and reset:
  - Clock is clk.
  - Reset rst_n is synchronous, active-low.
  - With rst_n = 0 at a posedge: state <= IDLE; pc, retired and the internal A/B/C registers <= 0.
- Memory port outputs are combinational from state.
  - write2 is also gated by rst_n, so no memory write happens at a reset edge, including reset during EXEC.
  - Outside EXEC: write2 = 0.
  - Outside active fetch/operand states: addresses and dataIn2 = 0.
- All PC arithmetic (PC+1, PC+2, PC+3) is modulo 2^WORD_SIZE.
- IDLE:
  - Memory idle; busy = 0, halted = 0.
  - start = 1: pc <= START_PC, go to FETCH_AB.
- FETCH_AB: add1 = pc, add2 = pc+1, reads. Next: FETCH_C.
- FETCH_C:
  - Latch A <= dataOut1, B <= dataOut2.
  - Drive add1 = pc+2 (read); port 2 idle.
  - Next: OPER.
- OPER:
  - Latch C <= dataOut1.
  - Drive add1 = A, add2 = B (reads).
  - Next: EXEC.
- EXEC:
  - diff = dataOut2 - dataOut1, WORD_SIZE bits, two's-complement wrap.
  - Drive add2 = B, dataIn2 = diff, write2 = 1.
  - Taken when diff is signed <= 0 (diff == 0 or diff[MSB] = 1).
  - retired <= retired + 1.
  - Not taken: pc <= pc+3, next FETCH_AB.
  - Taken and C[MSB] = 0: pc <= C, next FETCH_AB.
  - Taken and C[MSB] = 1 (negative target): pc <= C, next HALT. The write still occurs.
- HALT:
  - halted = 1, memory idle.
  - start = 1: pc <= START_PC, retired unchanged, go to FETCH_AB.
- Timing:
  - 4 cycles per instruction, fixed.
  - Write in EXEC commits at that edge, so the next FETCH_AB reads updated memory. A self-modifying operand fetch therefore sees the new value.
- start in a busy state is ignored.
- A == B is legal: diff = 0, so the branch is always taken.

Optional Feature:
- Macro: SUBLEQ_SELF_LOOP_HALT_EN.
- Defined: in EXEC, a taken branch with C == pc (the current instruction address, i.e. an infinite self-loop) also goes to HALT with pc <= C. The write still occurs.
- Not defined: the self-loop executes forever, 4 cycles per iteration, and retired keeps counting.

Test Plan:
1. Not-taken path:
   - Stimulus: mem[0..2] = {10,11,3}, mem[10] = 5, mem[11] = 7; reset, then start.
   - Response: 4 cycles after FETCH_AB, mem[11] = 2, pc = 3, retired = 1.
2. Taken, zero result:
   - Stimulus: mem[0..2] = {10,11,6}, mem[10] = mem[11] = 9.
   - Response: mem[11] = 0, pc = 6.
3. Taken, negative wrap:
   - Stimulus: mem[0..2] = {10,11,6}, mem[10] = 1, mem[11] = 0.
   - Response: mem[11] = 0xFFFF, pc = 6.
4. Halt and restart:
   - Stimulus: mem[0..2] = {10,10,0xFFFF}, then pulse start again.
   - Response: mem[10] = 0; halted = 1 and busy = 0 in the cycle after EXEC; pc = 0xFFFF. After start, pc = 0, halted = 0, retired = 1 preserved.
5. Reset mid-EXEC:
   - Stimulus: rst_n = 0 during the EXEC cycle of test 1.
   - Response: write2 = 0 that cycle, mem[11] stays 7; next cycle state IDLE, pc = 0, retired = 0.
6. Self-loop:
   - Stimulus: mem[0..2] = {10,10,0}.
   - Response with SUBLEQ_SELF_LOOP_HALT_EN: halted after 1 instruction, pc = 0.
   - Response without it: busy stays 1 and retired = 5 after 20 cycles.
